// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer
// ---------------------------------------------------------------------------
// Command front-end for the single-precision fpu block. Accepts tagged
// operations over valid/ready into a command FIFO and issues at most one per
// cycle into the fpu. It tracks the fpu's one-cycle registered latency and
// returns results in order, with tags, through a 4-entry result FIFO.
//
// Optional build macro: FPU_SEQ_DIV_TRAP_EN
//   defined   : DIV ops are sent to the fpu as MUL and their result is
//               replaced by a quiet NaN (32'h7FC00000) at capture.
//   undefined : DIV is issued unchanged and fpu_o is captured verbatim.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake (cmd_ready = FIFO not full)
//   cmd_a, cmd_b, cmd_op     operands and opcode (00 ADD, 01 SUB, 10 DIV, 11 MUL)
//   cmd_tag                  opaque tag returned with the result
//   fpu_a, fpu_b, fpu_opcode drive the fpu inputs from issue stage S1
//   fpu_o                    fpu output, valid for S2 while s2_valid is set
//   res_valid/res_ready      result handshake
//   res_data, res_tag        head of the result FIFO
//   busy                     any work queued, in flight or not yet popped
// ---------------------------------------------------------------------------
module fpu_op_sequencer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [1:0]       cmd_op,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [31:0]      fpu_a,
  output logic [31:0]      fpu_b,
  output logic [1:0]       fpu_opcode,
  input  logic [31:0]      fpu_o,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RDEPTH = 4;

`ifdef FPU_SEQ_DIV_TRAP_EN
  localparam logic [1:0]  OP_DIV = 2'b10;
  localparam logic [1:0]  OP_MUL = 2'b11;
  localparam logic [31:0] QNAN   = 32'h7FC00000;
`endif

  // command FIFO
  logic [31:0]      cq_a   [DEPTH];
  logic [31:0]      cq_b   [DEPTH];
  logic [1:0]       cq_op  [DEPTH];
  logic [TAG_W-1:0] cq_tag [DEPTH];
  logic [AW-1:0]    cq_wr, cq_rd;
  logic [CW-1:0]    cq_count;

  // issue stage S1 and tracking stage S2
  logic             s1_valid;
  logic [31:0]      s1_a, s1_b;
  logic [1:0]       s1_op;
  logic [TAG_W-1:0] s1_tag;
  logic             s2_valid;
  logic [TAG_W-1:0] s2_tag;
`ifdef FPU_SEQ_DIV_TRAP_EN
  logic [1:0]       s2_op;
`endif

  // result FIFO
  logic [31:0]      rq_data [RDEPTH];
  logic [TAG_W-1:0] rq_tag  [RDEPTH];
  logic [1:0]       rq_wr, rq_rd;
  logic [2:0]       res_count;

  logic             cmd_push, issue, credits_ok;
  logic             res_push, res_pop;
  logic [2:0]       committed;
  logic [31:0]      cap_data;

  assign cmd_ready = (cq_count != CW'(DEPTH));
  assign cmd_push  = cmd_valid && cmd_ready;

  // Every op in S1/S2 or in the result FIFO owns a result slot; the fpu
  // cannot stall, so issue only while a free slot is guaranteed.
  assign committed  = {2'b00, s1_valid} + {2'b00, s2_valid} + res_count;
  assign credits_ok = (committed < 3'd4);
  assign issue      = (cq_count != '0) && credits_ok;

  assign res_valid = (res_count != 3'd0);
  assign res_pop   = res_valid && res_ready;
  assign res_push  = s2_valid;

`ifdef FPU_SEQ_DIV_TRAP_EN
  assign fpu_opcode = (s1_op == OP_DIV) ? OP_MUL : s1_op;
  assign cap_data   = (s2_op == OP_DIV) ? QNAN : fpu_o;
`else
  assign fpu_opcode = s1_op;
  assign cap_data   = fpu_o;
`endif

  assign fpu_a    = s1_a;
  assign fpu_b    = s1_b;
  assign res_data = rq_data[rq_rd];
  assign res_tag  = rq_tag[rq_rd];

  assign busy = (cq_count != '0) || s1_valid || s2_valid || (res_count != 3'd0);

  // command FIFO storage is never observed before it is written
  always_ff @(posedge clk) begin
    if (cmd_push) begin
      cq_a[cq_wr]   <= cmd_a;
      cq_b[cq_wr]   <= cmd_b;
      cq_op[cq_wr]  <= cmd_op;
      cq_tag[cq_wr] <= cmd_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cq_wr    <= '0;
      cq_rd    <= '0;
      cq_count <= '0;
    end else begin
      if (cmd_push) cq_wr <= cq_wr + 1'b1;
      if (issue)    cq_rd <= cq_rd + 1'b1;
      case ({cmd_push, issue})
        2'b10:   cq_count <= cq_count + 1'b1;
        2'b01:   cq_count <= cq_count - 1'b1;
        default: cq_count <= cq_count;
      endcase
    end
  end

  // S1 data holds its last value when nothing issues
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
      s1_tag   <= '0;
    end else begin
      s1_valid <= issue;
      if (issue) begin
        s1_a   <= cq_a[cq_rd];
        s1_b   <= cq_b[cq_rd];
        s1_op  <= cq_op[cq_rd];
        s1_tag <= cq_tag[cq_rd];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_tag   <= '0;
`ifdef FPU_SEQ_DIV_TRAP_EN
      s2_op    <= '0;
`endif
    end else begin
      s2_valid <= s1_valid;
      s2_tag   <= s1_tag;
`ifdef FPU_SEQ_DIV_TRAP_EN
      s2_op    <= s1_op;
`endif
    end
  end

  // result storage is cleared so res_data/res_tag read zero out of reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RDEPTH; i++) begin
        rq_data[i] <= '0;
        rq_tag[i]  <= '0;
      end
      rq_wr     <= '0;
      rq_rd     <= '0;
      res_count <= '0;
    end else begin
      if (res_push) begin
        rq_data[rq_wr] <= cap_data;
        rq_tag[rq_wr]  <= s2_tag;
        rq_wr          <= rq_wr + 1'b1;
      end
      if (res_pop) rq_rd <= rq_rd + 1'b1;
      case ({res_push, res_pop})
        2'b10:   res_count <= res_count + 1'b1;
        2'b01:   res_count <= res_count - 1'b1;
        default: res_count <= res_count;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_op_sequencer.sv
module tb_fpu_op_sequencer;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [31:0]      cmd_a, cmd_b;
  logic [1:0]       cmd_op;
  logic [TAG_W-1:0] cmd_tag;
  logic [31:0]      fpu_a, fpu_b;
  logic [1:0]       fpu_opcode;
  logic [31:0]      fpu_o;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic [TAG_W-1:0] res_tag;
  logic             busy;

  int checks = 0;
  int failures = 0;

  // scoreboard entries: {expected data, expected tag}
  logic [31+TAG_W:0] sb[$];

  fpu_op_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_opcode(fpu_opcode), .fpu_o(fpu_o),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_tag(res_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic real f2r(input logic [31:0] f);
    int  e;
    real r;
    e = int'(f[30:23]);
    if (e == 0) return 0.0;
    r = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** real'(e - 127));
    return f[31] ? -r : r;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic       s;
    int         e;
    int         fr;
    real        v;
    logic [7:0] eb;
    logic [22:0] fb;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    v = s ? -r : r;
    e = 127;
    while (v >= 2.0) begin v = v / 2.0; e++; end
    while (v < 1.0) begin v = v * 2.0; e--; end
    fr = $rtoi((v - 1.0) * 8388608.0 + 0.5);
    eb = e[7:0];
    fb = fr[22:0];
    return {s, eb, fb};
  endfunction

  // fpu model: one-cycle registered latency, no DIV (output holds), no reset
  always_ff @(posedge clk) begin
    case (fpu_opcode)
      2'b00:   fpu_o <= r2f(f2r(fpu_a) + f2r(fpu_b));
      2'b01:   fpu_o <= r2f(f2r(fpu_a) - f2r(fpu_b));
      2'b11:   fpu_o <= r2f(f2r(fpu_a) * f2r(fpu_b));
      default: fpu_o <= fpu_o;
    endcase
  end

  task automatic drive_cmd(input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] op, input logic [TAG_W-1:0] tag);
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    cmd_tag   = tag;
  endtask

  // offer one command and wait (bounded) for acceptance
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] op, input logic [TAG_W-1:0] tag,
                      input logic [31:0] exp, output bit ok);
    ok = 1'b0;
    drive_cmd(a, b, op, tag);
    for (int c = 0; c < 20; c++) begin
      if (cmd_ready) begin
        sb.push_back({exp, tag});
        @(posedge clk);
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_flags: res_valid=%b busy=%b cmd_ready=%b, want 0 0 1",
               res_valid, busy, cmd_ready);
    end
    checks++;
    if (fpu_a !== 32'h0 || fpu_b !== 32'h0 || fpu_opcode !== 2'b00 ||
        res_data !== 32'h0 || res_tag !== '0) begin
      failures++;
      $display("FAIL reset_data: fpu_a=%h fpu_b=%h op=%b res_data=%h res_tag=%h, want all 0",
               fpu_a, fpu_b, fpu_opcode, res_data, res_tag);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_latency(input string name, input logic [TAG_W-1:0] tag);
    logic [31+TAG_W:0] e;
    res_ready = 1'b1;
    drive_cmd(32'h3F800000, 32'h40000000, 2'b00, tag);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready: cmd_ready=%b want 1", name, cmd_ready);
    end
    sb.push_back({32'h40400000, tag});
    @(posedge clk);                       // E0: accept
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL %s_busy: busy=%b want 1", name, busy);
    end
    for (int k = 1; k <= 2; k++) begin    // after E1, E2
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0) begin
        failures++;
        $display("FAIL %s_early: res_valid=%b at E%0d want 0", name, res_valid, k);
      end
    end
    @(negedge clk);                       // after E3
    e = sb.pop_front();
    checks++;
    if (res_valid !== 1'b1 || res_data !== e[31+TAG_W:TAG_W] || res_tag !== e[TAG_W-1:0]) begin
      failures++;
      $display("FAIL %s_result: valid=%b data=%h tag=%0d want 1 %h %0d", name,
               res_valid, res_data, res_tag, e[31+TAG_W:TAG_W], e[TAG_W-1:0]);
    end
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle: res_valid=%b busy=%b want 0 0", name, res_valid, busy);
    end
  endtask

  task automatic test_back_to_back;
    logic [31+TAG_W:0] e;
    int n = 0;
    int last = 0;
    res_ready = 1'b1;
    drive_cmd(32'h40000000, 32'h40400000, 2'b11, 4'd1);
    sb.push_back({32'h40C00000, 4'd1});
    @(posedge clk);
    @(negedge clk);
    drive_cmd(32'h40400000, 32'h3FC00000, 2'b01, 4'd2);
    sb.push_back({32'h3FC00000, 4'd2});
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 0; c < 12 && sb.size() > 0; c++) begin
      if (res_valid) begin
        e = sb.pop_front();
        checks++;
        if (res_data !== e[31+TAG_W:TAG_W] || res_tag !== e[TAG_W-1:0]) begin
          failures++;
          $display("FAIL b2b_result: data=%h tag=%0d want %h %0d",
                   res_data, res_tag, e[31+TAG_W:TAG_W], e[TAG_W-1:0]);
        end
        if (n == 1) begin
          checks++;
          if (c != last + 1) begin
            failures++;
            $display("FAIL b2b_spacing: gap=%0d cycles want 1", c - last);
          end
        end
        last = c;
        n++;
      end
      @(negedge clk);
    end
    checks++;
    if (n != 2) begin
      failures++;
      $display("FAIL b2b_count: got %0d results want 2", n);
      sb.delete();
    end
  endtask

  task automatic test_div;
    logic [31+TAG_W:0] e;
    logic [31:0] div_exp;
    int n = 0;
`ifdef FPU_SEQ_DIV_TRAP_EN
    div_exp = 32'h7FC00000;
`else
    div_exp = 32'h40400000;   // fpu holds the preceding ADD result
`endif
    res_ready = 1'b1;
    drive_cmd(32'h3F800000, 32'h40000000, 2'b00, 4'd4);
    sb.push_back({32'h40400000, 4'd4});
    @(posedge clk); @(negedge clk);
    drive_cmd(32'h40800000, 32'h40000000, 2'b10, 4'd5);
    sb.push_back({div_exp, 4'd5});
    @(posedge clk); @(negedge clk);
    drive_cmd(32'h40000000, 32'h40000000, 2'b00, 4'd6);
    sb.push_back({32'h40800000, 4'd6});
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 0; c < 15 && sb.size() > 0; c++) begin
      if (res_valid) begin
        e = sb.pop_front();
        n++;
        checks++;
        if (res_data !== e[31+TAG_W:TAG_W] || res_tag !== e[TAG_W-1:0]) begin
          failures++;
          $display("FAIL div_result%0d: data=%h tag=%0d want %h %0d", n,
                   res_data, res_tag, e[31+TAG_W:TAG_W], e[TAG_W-1:0]);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (n != 3) begin
      failures++;
      $display("FAIL div_count: got %0d results want 3", n);
      sb.delete();
    end
  endtask

  task automatic test_full_and_drain;
    logic [31+TAG_W:0] e;
    bit ok;
    int acc = 0;
    int n = 0;
    logic [TAG_W-1:0] t;
    res_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      t = TAG_W'(i);
      send(r2f(real'(i + 1)), 32'h3F800000, 2'b00, t, r2f(real'(i + 2)), ok);
      if (ok) acc++;
    end
    checks++;
    if (acc != 8) begin
      failures++;
      $display("FAIL full_accept: accepted %0d want 8", acc);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0 || res_valid !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL full_state: cmd_ready=%b res_valid=%b busy=%b want 0 1 1",
               cmd_ready, res_valid, busy);
    end
    // head must stay put under backpressure
    e = sb[0];
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (res_data !== e[31+TAG_W:TAG_W] || res_tag !== e[TAG_W-1:0]) begin
        failures++;
        $display("FAIL hold_head: data=%h tag=%0d want %h %0d",
                 res_data, res_tag, e[31+TAG_W:TAG_W], e[TAG_W-1:0]);
      end
      @(negedge clk);
    end

    // push offered on a full command FIFO while one result pops
    drive_cmd(r2f(9.0), 32'h3F800000, 2'b00, 4'd8);
    res_ready = 1'b1;
    e = sb.pop_front();
    checks++;
    if (res_data !== e[31+TAG_W:TAG_W] || res_tag !== e[TAG_W-1:0] || cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL pushpop_head: data=%h tag=%0d rdy=%b want %h %0d 0",
               res_data, res_tag, cmd_ready, e[31+TAG_W:TAG_W], e[TAG_W-1:0]);
    end
    @(posedge clk); @(negedge clk);
    res_ready = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL pushpop_refused: cmd_ready=%b want 0", cmd_ready);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL pushpop_reopen: cmd_ready=%b want 1", cmd_ready);
    end
    sb.push_back({r2f(10.0), 4'd8});
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;

    res_ready = 1'b1;
    for (int c = 0; c < 40 && sb.size() > 0; c++) begin
      if (res_valid) begin
        e = sb.pop_front();
        n++;
        checks++;
        if (res_data !== e[31+TAG_W:TAG_W] || res_tag !== e[TAG_W-1:0]) begin
          failures++;
          $display("FAIL drain_result: data=%h tag=%0d want %h %0d",
                   res_data, res_tag, e[31+TAG_W:TAG_W], e[TAG_W-1:0]);
        end
      end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (n != 8 || res_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL drain_done: results=%0d res_valid=%b busy=%b want 8 0 0",
               n, res_valid, busy);
      sb.delete();
    end
  endtask

  task automatic test_reset_mid;
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_cmd(32'h40000000, 32'h40000000, 2'b00, TAG_W'(9 + i));
      @(posedge clk); @(negedge clk);
    end
    cmd_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre: busy=%b want 1", busy);
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_flags: res_valid=%b busy=%b cmd_ready=%b want 0 0 1",
               res_valid, busy, cmd_ready);
    end
    rst = 1'b0;
    sb.delete();
    repeat (4) @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_dropped: res_valid=%b busy=%b want 0 0", res_valid, busy);
    end
    test_latency("postrst", 4'd12);
  endtask

  initial begin
    test_reset();
    test_latency("add", 4'd3);
    test_back_to_back();
    test_div();
    test_full_and_drain();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
